float_sqrt: RTL

- IEEE-754 single-precision square-root unit. It is the responder side of the codebase's operand/result strobe-acknowledge protocol, the same protocol the collision datapath uses as initiator towards adder/multiplier/divider.
- Serves distance and normal computations: sqrt of a sum of squares feeding reciprocal, depth and contact-point stages.
- Iterative, one root bit per cycle, one operation in flight.

---
 rtl/float_sqrt.sv | 135 +++++++++++++
 1 files changed

// File: rtl/float_sqrt.sv
// float_sqrt: IEEE-754 single-precision square root, one root bit per cycle.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   input_a      operand (IEEE-754 single)
//   input_a_stb  operand valid from the initiator
//   input_a_ack  ready to accept an operand
//   output_z     result (IEEE-754 single), stable while output_z_stb is high
//   output_z_stb result valid
//   output_z_ack initiator accepts the result
module float_sqrt #(
    parameter int ROOT_BITS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [3:0] {
        GET_A, UNPACK, SPECIAL, NORMALISE, ALIGN, ROOT, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, next_state;
    logic [31:0] a;
    logic [23:0] m;
    logic signed [9:0] e, rexp;
    logic [49:0] rad;
    logic [25:0] rem;
    logic [ROOT_BITS-1:0] root;
    logic [4:0] cnt;
    logic ack_d, stb_d;

    logic a_nan, a_inf, a_zero, a_den, a_special, ge, up;
    logic [24:0] rad25, sig;
    logic [27:0] trial, sub;

    assign a_inf     = &a[30:23];
    assign a_nan     = a_inf && |a[22:0];
    assign a_zero    = ~|a[30:0];
    assign a_den     = ~|a[30:23];
    assign a_special = a_inf || a_zero || a[31];
    // Odd exponents borrow one radicand bit so the halved exponent is exact.
    assign rad25     = e[0] ? {m, 1'b0} : {1'b0, m};
    assign trial     = {rem, rad[49:48]};
    assign sub       = {1'b0, root, 2'b01};
    assign ge        = trial >= sub;
    // Round to nearest even: guard is root[0], sticky is a nonzero remainder.
    assign up        = root[0] & ((|rem) | root[1]);
    assign sig       = {1'b0, root[24:1]} + 25'(up);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= GET_A;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            GET_A:     next_state = (input_a_stb && input_a_ack) ? UNPACK : GET_A;
            UNPACK:    next_state = SPECIAL;
            SPECIAL:   next_state = a_special ? PUT_Z : a_den ? NORMALISE : ALIGN;
            NORMALISE: next_state = m[22] ? ALIGN : NORMALISE;
            ALIGN:     next_state = ROOT;
            ROOT:      next_state = (cnt == 5'(ROOT_BITS - 2)) ? ROUND : ROOT;
            ROUND:     next_state = PACK;
            PACK:      next_state = PUT_Z;
            PUT_Z:     next_state = (output_z_stb && output_z_ack) ? GET_A : PUT_Z;
            default:   next_state = GET_A;
        endcase
    end

    // Handshake outputs are registered: ack follows the state being entered,
    // and the result strobe rises on the second PUT_Z cycle.
    always_comb begin
        ack_d = next_state == GET_A;
        stb_d = state == PUT_Z && next_state == PUT_Z;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            a            <= '0;
            m            <= '0;
            e            <= '0;
            rexp         <= '0;
            rad          <= '0;
            rem          <= '0;
            root         <= '0;
            cnt          <= '0;
        end else begin
            input_a_ack  <= ack_d;
            output_z_stb <= stb_d;
            case (state)
                GET_A: if (input_a_stb && input_a_ack) a <= input_a;
                UNPACK: begin
                    m <= {~a_den, a[22:0]};
                    e <= a_den ? -10'sd126 : $signed({2'b0, a[30:23]}) - 10'sd127;
                end
                SPECIAL: if (a_special)
                    output_z <= (a_nan || (a[31] && !a_zero)) ? 32'h7FC0_0000 :
                                a_zero ? {a[31], 31'b0} : 32'h7F80_0000;
                NORMALISE: begin
                    m <= m << 1;
                    e <= e - 10'sd1;
                end
                ALIGN: begin
                    // Radicand is in [1,4), so the leading root bit is always 1
                    // and its iteration reduces to subtracting 1 from the top pair.
                    rad  <= {rad25[22:0], 27'b0};
                    rem  <= {24'b0, rad25[24:23] - 2'd1};
                    root <= ROOT_BITS'(1);
                    cnt  <= '0;
                    rexp <= e >>> 1;
                end
                ROOT: begin
                    rad  <= rad << 2;
                    cnt  <= cnt + 5'd1;
                    rem  <= 26'(ge ? trial - sub : trial);
                    root <= {root[ROOT_BITS-2:0], ge};
                end
                ROUND: begin
                    m    <= sig[24] ? sig[24:1] : sig[23:0];
                    rexp <= sig[24] ? rexp + 10'sd1 : rexp;
                end
                PACK: output_z <= {1'b0, 8'(rexp + 10'sd127), m[22:0]};
                default: ;
            endcase
        end
    end
endmodule
